uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame; legal range 5..9.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port tx_data  input  DATA_WIDTH: payload, sampled only on handshake.
REQ-006 SHALL have port tx_valid  input  1: requester has a frame to send.
REQ-007 SHALL have port tx_ready  output  1: controller can accept a frame this cycle.
REQ-008 SHALL have port tx  output  1: serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1: frame in progress (any state other than IDLE).
REQ-010 SHALL have port tx_done  output  1: one-cycle pulse on frame completion, registered.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL drive tx_ready high only in IDLE; handshake = tx_valid && tx_ready at a rising edge.
REQ-013 SHALL, on handshake, latch tx_data, clear the bit counter and baud counter, and enter START.
REQ-014 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles, timed by a baud counter 0..CLKS_PER_BIT-1 that wraps at each bit boundary.
REQ-015 SHALL drive tx = 0 in START, tx = latched bit n (LSB first) in DATA bit n, tx = parity in PARITY, and tx = 1 in STOP and IDLE.
REQ-016 SHALL leave DATA after bit DATA_WIDTH-1 for PARITY when parity is compiled in, otherwise for STOP.
REQ-017 SHALL, after the last STOP cycle, enter IDLE and assert tx_done for exactly that first IDLE cycle, coincident with tx_ready = 1.
REQ-018 SHALL accept a new handshake in the tx_done cycle, giving a back-to-back frame period of (DATA_WIDTH+2)*CLKS_PER_BIT+1 cycles, plus CLKS_PER_BIT with parity.
REQ-019 SHALL ignore tx_valid and tx_data changes while busy; the in-flight frame is unaffected.
REQ-020 SHALL keep tx stable (glitch-free) within each bit period; tx changes only at bit boundaries.
REQ-021 SHALL keep the baud counter width at $clog2(CLKS_PER_BIT) bits, with no overflow at CLKS_PER_BIT-1.

Reset
REQ-022 SHALL, on rst_n low, immediately force state IDLE, tx = 1, tx_ready = 1 once released, busy = 0, tx_done = 0, and clear all counters and the data register.
REQ-023 SHALL, on reset asserted mid-frame, abort the frame with no tx_done pulse; the line returns high asynchronously.
REQ-024 SHALL accept a handshake on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL compile the PARITY state and an even-parity bit (XOR of the latched payload) only when UART_TX_PARITY_EN is defined.
REQ-026 SHALL, without UART_TX_PARITY_EN, have no PARITY state, a frame of DATA_WIDTH+2 bits, and no parity logic.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-027 SHALL cover a single frame, no parity: send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulses once 41 cycles after the handshake edge.
REQ-028 SHALL cover parity: with UART_TX_PARITY_EN, send 0x01 -> parity bit 1; send 0xA5 -> parity bit 0; tx_done pulses at cycle 45.
REQ-029 SHALL cover back-to-back frames: tx_valid held high with 0x3C then 0xC3 -> second handshake in the tx_done cycle; no extra idle bit between the two STOP/START bits.
REQ-030 SHALL cover busy-input immunity: tx_data changed to 0xFF and tx_valid toggled during DATA -> serial output still matches the first payload; tx_ready = 0 throughout.
REQ-031 SHALL cover reset mid-frame: rst_n pulsed low during DATA bit 3 -> tx = 1 immediately; busy = 0; no tx_done; a new frame 0x55 is sent correctly after release.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: valid/ready frame handshake, LSB-first serialisation, registered line output.
// Optional even-parity bit after the payload when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_WIDTH);

    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitMax  = BitW'(DATA_WIDTH - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  baud_wrap;

    assign baud_wrap = (baud_q == BaudMax);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (state_q != StIdle) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d = StStart;
                    baud_d  = '0;
                    bit_d   = '0;
                    data_d  = tx_data;
                end
            end
            StStart: begin
                if (baud_wrap) state_d = StData;
            end
            StData: begin
                if (baud_wrap) begin
                    if (bit_q == BitMax) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_wrap) state_d = StStop;
            end
`endif
            StStop: begin
                if (baud_wrap) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the bit boundary.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = ^data_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised self-checking bench for uart_tx_ctrl; the expected line is built from the frame
// format (start, payload LSB first, optional parity, stop) rather than from the FSM.
module tb_uart_tx_ctrl;

    localparam int unsigned Cpb = 4;
    localparam int unsigned Dw  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBits = Dw + 3;
`else
    localparam int unsigned NBits = Dw + 2;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [Dw-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    logic          tx_done;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(Cpb),
        .DATA_WIDTH  (Dw)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level for frame bit position idx.
    function automatic logic ref_bit(input logic [Dw-1:0] p, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= Dw) return p[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == Dw + 1) return ^p;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle (or in its tx_done cycle); returns at the negedge
    // of the tx_done cycle.
    task automatic send_frame(input logic [Dw-1:0] p, input bit keep_valid, input bit mess);
        tx_data  = p;
        tx_valid = 1'b1;
        check("ready_at_handshake", tx_ready, 1);
        @(posedge clk);
        #1;
        if (!keep_valid) tx_valid = 1'b0;
        for (int i = 0; i < int'(NBits * Cpb); i++) begin
            @(negedge clk);
            check("tx_bit", tx, ref_bit(p, i / Cpb));
            check("busy_high", busy, 1);
            check("ready_low", tx_ready, 0);
            check("done_low", tx_done, 0);
            if (mess) begin
                tx_data  = '1;
                tx_valid = 1'($urandom_range(0, 1));
            end
        end
        if (mess) tx_valid = keep_valid;
        @(negedge clk);
        check("done_pulse", tx_done, 1);
        check("ready_in_done", tx_ready, 1);
        check("tx_idle_in_done", tx, 1);
        check("busy_in_done", busy, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done_low", tx_done, 0);
            check("idle_tx_high", tx, 1);
            check("idle_ready", tx_ready, 1);
        end
    endtask

    initial begin
        logic [Dw-1:0] p;
        bit            keep;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_ready", tx_ready, 1);

        // Handshake on the first edge after release.
        rst_n = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0);
        idle_cycles(2);
        send_frame(8'h01, 1'b0, 1'b0);
        idle_cycles(1);

        // Back-to-back: second handshake lands in the tx_done cycle.
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        idle_cycles(1);

        // Inputs churn while busy.
        send_frame(8'h96, 1'b0, 1'b1);
        idle_cycles(2);

        // Reset during DATA bit 3.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int i = 0; i < 18; i++) @(negedge clk);
        check("pre_reset_bit3", tx, ref_bit(8'h00, 4));
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", tx_done, 0);
        check("abort_ready", tx_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset_done", tx_done, 0);
            check("in_reset_tx", tx, 1);
        end
        rst_n = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0);
        idle_cycles(1);

        for (int k = 0; k < 8; k++) begin
            p    = Dw'($urandom);
            keep = (k < 7) ? bit'($urandom_range(0, 1)) : 1'b0;
            send_frame(p, keep, bit'($urandom_range(0, 1)));
            if (!keep) idle_cycles(int'($urandom_range(1, 3)));
        end
        tx_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
